// File: rtl/word_frame_if.sv
// Payload-side and serializer-side signals of the transmit framer.
// The slave modport is the framer's own view of these signals.
interface word_frame_if;
    logic        DIPUSH;
    logic [63:0] DIN;
    logic        DIFULL;
    logic        OVERFLOW;
    logic        DOREQ;
    logic        DOPUSH;
    logic [63:0] DOUT;
    logic        SYNC_DONE;

    modport master (
        output DIPUSH, DIN, DOREQ,
        input  DIFULL, OVERFLOW, DOPUSH, DOUT, SYNC_DONE
    );

    modport slave (
        input  DIPUSH, DIN, DOREQ,
        output DIFULL, OVERFLOW, DOPUSH, DOUT, SYNC_DONE
    );
endinterface

// File: rtl/word_frame_tx.sv
// Transmit framer: emits a sync-word burst after link init, then forwards
// buffered payload words, with the idle word filling any gaps.
module word_frame_tx #(
    parameter logic [63:0] SYNC_WORD  = 64'hF731_8CEF_137F_FEC8,
    parameter int          SYNC_COUNT = 4,
    parameter logic [63:0] IDLE_WORD  = 64'h0000_0000_0000_0000,
    parameter int          FIFO_AW    = 2
) (
    input  logic          CLK,
    input  logic          RSTX,
    input  logic          PHY_INIT,
    word_frame_if.slave   bus
);
    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   EMPTY_CNT = {(FIFO_AW+1){1'b0}};
    localparam logic [7:0]         SYNC_LAST = 8'(SYNC_COUNT - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_sync_cnt;
    logic [7:0]         w_sync_cnt_nxt;
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [63:0]        r_mem [DEPTH];
    logic               r_overflow;
    logic               r_dopush;
    logic [63:0]        r_dout;
    logic [63:0]        w_dout_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == EMPTY_CNT);
    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    assign w_push  = bus.DIPUSH & ~w_full & ~PHY_INIT;
    assign w_drop  = bus.DIPUSH &  w_full & ~PHY_INIT;

    // Next-state, sync counter, next output word and FIFO pop decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_dout_nxt     = r_dout;
        w_pop          = 1'b0;
        if (PHY_INIT) begin
            w_state_nxt    = ST_INIT;
            w_sync_cnt_nxt = 8'd0;
            if (bus.DOREQ) begin
                w_dout_nxt = IDLE_WORD;
            end else begin
                w_dout_nxt = r_dout;
            end
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_state_nxt = ST_SYNC;
                    if (bus.DOREQ) begin
                        w_dout_nxt = IDLE_WORD;
                    end else begin
                        w_dout_nxt = r_dout;
                    end
                end
                ST_SYNC: begin
                    if (bus.DOREQ) begin
                        w_dout_nxt = SYNC_WORD;
                        if (r_sync_cnt == SYNC_LAST) begin
                            w_state_nxt    = ST_DATA;
                            w_sync_cnt_nxt = 8'd0;
                        end else begin
                            w_sync_cnt_nxt = r_sync_cnt + 8'd1;
                        end
                    end else begin
                        w_dout_nxt = r_dout;
                    end
                end
                ST_DATA: begin
                    if (bus.DOREQ && !w_empty) begin
                        w_dout_nxt = r_mem[r_rptr];
                        w_pop      = 1'b1;
                    end else if (bus.DOREQ) begin
                        w_dout_nxt = IDLE_WORD;
                    end else begin
                        w_dout_nxt = r_dout;
                    end
                end
                default: begin
                    w_state_nxt    = ST_INIT;
                    w_sync_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    // State register and sync-word counter.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state    <= ST_INIT;
            r_sync_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; PHY_INIT flushes them all.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_wptr     <= {FIFO_AW{1'b0}};
            r_rptr     <= {FIFO_AW{1'b0}};
            r_count    <= EMPTY_CNT;
            r_overflow <= 1'b0;
        end else if (PHY_INIT) begin
            r_wptr     <= {FIFO_AW{1'b0}};
            r_rptr     <= {FIFO_AW{1'b0}};
            r_count    <= EMPTY_CNT;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
            if (w_pop)  r_rptr <= r_rptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{FIFO_AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 64'd0;
        end else if (w_push) begin
            r_mem[r_wptr] <= bus.DIN;
        end
    end

    // Registered serializer-side outputs.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_dopush <= 1'b0;
            r_dout   <= 64'd0;
        end else begin
            r_dopush <= bus.DOREQ;
            r_dout   <= w_dout_nxt;
        end
    end

    assign bus.DOPUSH    = r_dopush;
    assign bus.DOUT      = r_dout;
    assign bus.DIFULL    = w_full;
    assign bus.OVERFLOW  = r_overflow;
    assign bus.SYNC_DONE = (r_state == ST_DATA);
endmodule

// File: tb/tb_word_frame_tx.sv
// Directed bench for word_frame_tx: a queue-based link model checked every
// cycle, plus literal expected word sequences for each scenario.
module tb_word_frame_tx;
    localparam logic [63:0] SYNC = 64'hF731_8CEF_137F_FEC8;
    localparam logic [63:0] IDLE = 64'h0000_0000_0000_0000;
    localparam int          NSYNC = 4;
    localparam int          DEPTH = 4;

    logic CLK = 1'b0;
    logic RSTX = 1'b0;
    logic PHY_INIT = 1'b1;

    word_frame_if bus ();

    word_frame_tx dut (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .PHY_INIT (PHY_INIT),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [63:0] got [$];

    // model: phase 0 = init, 1 = sync burst, 2 = data
    int          m_phase;
    int          m_sent;
    logic [63:0] m_q [$];
    logic        m_ovf;
    logic        m_dopush;
    logic [63:0] m_dout;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string nm, input logic [63:0] e [$]);
        chk({nm, " count"}, 64'(got.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s word%0d", nm, i), got[i], e[i]);
        end
        got.delete();
    endtask

    // Model update on each active edge from the inputs held since the last negedge.
    always @(posedge CLK) begin
        if (!RSTX) begin
            m_phase = 0; m_sent = 0; m_q.delete(); m_ovf = 1'b0;
            m_dopush = 1'b0; m_dout = IDLE;
        end else begin
            bit was_full;
            was_full = (m_q.size() == DEPTH);
            m_dopush = bus.DOREQ;
            if (bus.DOREQ) begin
                if (PHY_INIT || m_phase == 0) m_dout = IDLE;
                else if (m_phase == 1) m_dout = SYNC;
                else if (m_q.size() > 0) m_dout = m_q.pop_front();
                else m_dout = IDLE;
            end
            if (PHY_INIT) begin
                m_phase = 0; m_sent = 0; m_q.delete(); m_ovf = 1'b0;
            end else begin
                if (bus.DIPUSH) begin
                    if (was_full) m_ovf = 1'b1;
                    else m_q.push_back(bus.DIN);
                end
                if (m_phase == 0) m_phase = 1;
                else if (m_phase == 1 && bus.DOREQ) begin
                    m_sent++;
                    if (m_sent == NSYNC) begin m_phase = 2; m_sent = 0; end
                end
            end
        end
    end

    // Per-cycle comparison against the model, and capture of delivered words.
    always @(posedge CLK) begin
        #1;
        if (RSTX) begin
            chk("dopush", 64'(bus.DOPUSH), 64'(m_dopush));
            chk("dout", bus.DOUT, m_dout);
            chk("sync_done", 64'(bus.SYNC_DONE), 64'(m_phase == 2));
            chk("difull", 64'(bus.DIFULL), 64'(m_q.size() == DEPTH));
            chk("overflow", 64'(bus.OVERFLOW), 64'(m_ovf));
            if (bus.DOPUSH) got.push_back(bus.DOUT);
        end
    end

    task automatic step(input logic p, input logic push, input logic [63:0] d, input logic req);
        PHY_INIT   = p;
        bus.DIPUSH = push;
        bus.DIN    = d;
        bus.DOREQ  = req;
        @(negedge CLK);
    endtask

    initial begin
        logic [63:0] e [$];
        bus.DIPUSH = 1'b0; bus.DIN = 64'd0; bus.DOREQ = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst dopush", 64'(bus.DOPUSH), 64'd0);
        chk("rst dout", bus.DOUT, 64'd0);
        chk("rst overflow", 64'(bus.OVERFLOW), 64'd0);
        chk("rst sync_done", 64'(bus.SYNC_DONE), 64'd0);
        chk("rst difull", 64'(bus.DIFULL), 64'd0);
        RSTX = 1'b1;

        // 1: held in init, idle words delivered
        repeat (3) step(1'b1, 1'b0, 64'd0, 1'b1);
        e = '{IDLE, IDLE, IDLE};
        chk_list("t1", e);

        // 2: sync burst then idle
        repeat (8) step(1'b0, 1'b0, 64'd0, 1'b1);
        e = '{IDLE, SYNC, SYNC, SYNC, SYNC, IDLE, IDLE, IDLE};
        chk_list("t2", e);
        chk("t2 sync_done", 64'(bus.SYNC_DONE), 64'd1);

        // 3: three words, request every other cycle
        step(1'b0, 1'b1, 64'd1, 1'b0);
        step(1'b0, 1'b1, 64'd2, 1'b1);
        step(1'b0, 1'b1, 64'd3, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b0, 64'd0, 1'b1);
            step(1'b0, 1'b0, 64'd0, 1'b0);
        end
        e = '{64'd1, 64'd2, 64'd3, IDLE};
        chk_list("t3", e);

        // 4: overfill, then a full-push with same-cycle pop is still dropped
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 64'(10 + i), 1'b0);
        chk("t4 difull", 64'(bus.DIFULL), 64'd1);
        chk("t4 no ovf yet", 64'(bus.OVERFLOW), 64'd0);
        step(1'b0, 1'b1, 64'd14, 1'b0);
        chk("t4 overflow", 64'(bus.OVERFLOW), 64'd1);
        step(1'b0, 1'b1, 64'd15, 1'b1);
        repeat (4) step(1'b0, 1'b0, 64'd0, 1'b1);
        e = '{64'd10, 64'd11, 64'd12, 64'd13, IDLE};
        chk_list("t4", e);
        chk("t4 ovf sticky", 64'(bus.OVERFLOW), 64'd1);

        // 5: words pushed during the burst wait for its end
        step(1'b1, 1'b0, 64'd0, 1'b0);
        chk("t5 ovf cleared", 64'(bus.OVERFLOW), 64'd0);
        chk("t5 sync_done", 64'(bus.SYNC_DONE), 64'd0);
        step(1'b0, 1'b1, 64'd20, 1'b1);
        step(1'b0, 1'b1, 64'd21, 1'b1);
        repeat (6) step(1'b0, 1'b0, 64'd0, 1'b1);
        e = '{IDLE, SYNC, SYNC, SYNC, SYNC, 64'd20, 64'd21, IDLE};
        chk_list("t5", e);

        // 6: init pulse with queued words flushes them; push during init lost silently
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'(30 + i), 1'b0);
        step(1'b0, 1'b1, 64'd33, 1'b0);
        step(1'b0, 1'b1, 64'd34, 1'b0);
        chk("t6 ovf before", 64'(bus.OVERFLOW), 64'd1);
        step(1'b1, 1'b1, 64'd35, 1'b0);
        chk("t6 ovf cleared", 64'(bus.OVERFLOW), 64'd0);
        chk("t6 difull", 64'(bus.DIFULL), 64'd0);
        repeat (8) step(1'b0, 1'b0, 64'd0, 1'b1);
        e = '{IDLE, SYNC, SYNC, SYNC, SYNC, IDLE, IDLE, IDLE};
        chk_list("t6", e);

        step(1'b0, 1'b0, 64'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
